// File: rtl/sum_uart_tx.sv
// rtl/sum_uart_tx.sv - serialises "A+B=SS\r\n" for two latched 4-bit operands on an 8N1 UART pin
module sum_uart_tx #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       send_n,
   input  logic [3:0] op_a,
   input  logic [3:0] op_b,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_nx;
   logic [2:0]    byte_idx, byte_nx;
   logic          accept;
   logic          cell_end;
   logic          s1, s2, s3;
   logic          fall;
   logic [3:0]    a_q, b_q;
   logic [4:0]    sum_q;
   logic [7:0]    cur_byte;
   logic          tx_q, busy_q, done_q;

   function automatic logic [7:0] hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   assign fall     = s3 & ~s2;
   assign cell_end = (cnt == CNT_LAST);
   assign tx       = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;

   // Two-flop synchroniser plus history flop; preset high so reset release is never seen as a press
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= send_n;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Next-state logic: baud counter restarts on every state entry so every cell is CLKS_PER_BIT long
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      bit_nx   = bit_idx;
      byte_nx  = byte_idx;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (fall && !busy_q) begin
               accept   = 1'b1;
               state_nx = START;
               byte_nx  = 3'd0;
            end
         end
         START: begin
            if (cell_end) begin
               state_nx = DATA;
               cnt_nx   = '0;
               bit_nx   = 3'd0;
            end
         end
         DATA: begin
            if (cell_end) begin
               cnt_nx = '0;
               if (bit_idx == 3'd7) state_nx = STOP;
               else                 bit_nx   = bit_idx + 3'd1;
            end
         end
         STOP: begin
            if (cell_end) begin
               cnt_nx = '0;
               if (byte_idx == 3'd7) begin
                  state_nx = IDLE;
               end else begin
                  byte_nx  = byte_idx + 3'd1;
                  state_nx = START;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM state, baud counter and bit/byte indices
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= 3'd0;
         byte_idx <= 3'd0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         bit_idx  <= bit_nx;
         byte_idx <= byte_nx;
      end
   end

   // Operand snapshot so latch changes mid-message cannot corrupt the line
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_q   <= 4'h0;
         b_q   <= 4'h0;
         sum_q <= 5'h00;
      end else if (accept) begin
         a_q   <= op_a;
         b_q   <= op_b;
         sum_q <= {1'b0, op_a} + {1'b0, op_b};
      end
   end

   // Message byte currently being shifted out
   always_comb begin
      cur_byte = 8'h0A;
      case (byte_idx)
         3'd0: cur_byte = hex(a_q);
         3'd1: cur_byte = 8'h2B;
         3'd2: cur_byte = hex(b_q);
         3'd3: cur_byte = 8'h3D;
         3'd4: cur_byte = hex({3'b000, sum_q[4]});
         3'd5: cur_byte = hex(sum_q[3:0]);
         3'd6: cur_byte = 8'h0D;
         default: cur_byte = 8'h0A;
      endcase
   end

   // Registered outputs trail the state by one cycle, so busy/done align with the last tx cell
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_q   <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         case (state)
            START:   tx_q <= 1'b0;
            DATA:    tx_q <= cur_byte[bit_idx];
            default: tx_q <= 1'b1;
         endcase
         busy_q <= (state != IDLE);
         done_q <= busy_q && (state == IDLE);
      end
   end

endmodule

// File: tb/tb_sum_uart_tx.sv
// tb/tb_sum_uart_tx.sv - scoreboard bench for sum_uart_tx
module tb_sum_uart_tx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       send_n;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic       tx;
   logic       busy;
   logic       done;

   int checks = 0;
   int failures = 0;
   logic [7:0] exp_q[$];
   bit mon_abort;

   sum_uart_tx #(.CLK_FREQ(1600), .BAUD(100)) dut (
      .clk(clk), .reset_n(reset_n), .send_n(send_n),
      .op_a(op_a), .op_b(op_b), .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor helper: wait n falling edges, noting any reset seen meanwhile
   task automatic mon_wait(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!reset_n) mon_abort = 1'b1;
      end
   endtask

   // UART receiver monitor: decodes each frame and compares with the scoreboard
   initial begin
      logic [7:0] rx;
      logic st, sp, ex;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && tx === 1'b0) begin
            mon_abort = 1'b0;
            mon_wait(CPB / 2);
            st = tx;
            for (int i = 0; i < 8; i++) begin
               mon_wait(CPB);
               rx[i] = tx;
            end
            mon_wait(CPB);
            sp = tx;
            if (!mon_abort) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL rx_byte unexpected actual=%02h required=none", rx);
               end else begin
                  ex = (st === 1'b0) && (sp === 1'b1);
                  if (rx !== exp_q[0] || !ex) begin
                     failures++;
                     $display("FAIL rx_byte actual=%02h start=%b stop=%b required=%02h", rx, st, sp, exp_q[0]);
                  end
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   // Issue one press, check latency/busy/done and push the expected line
   task automatic run_msg(input logic [3:0] a, input logic [3:0] b, input logic [63:0] msg,
                          input int hold, input int p2);
      int bcnt, dcnt;
      bit fin, pbusy;
      for (int i = 0; i < 8; i++) exp_q.push_back(msg[63-8*i -: 8]);
      @(posedge clk);
      #2 op_a = a; op_b = b; send_n = 1'b0;
      bcnt = 0; dcnt = 0; fin = 1'b0; pbusy = 1'b0;
      for (int e = 0; e < hold + 3000 && !fin; e++) begin
         @(posedge clk);
         #1;
         if (e == 2) chk("latency_pre", {31'd0, tx}, 32'd1);
         if (e == 3) chk("latency_start", {31'd0, tx}, 32'd0);
         if (busy) bcnt++;
         if (done) dcnt++;
         if (pbusy && !busy) chk("done_at_busy_fall", {31'd0, done}, 32'd1);
         pbusy = busy;
         if (e > 3 && !busy && e >= hold - 1) fin = 1'b1;
         #1;
         if (e == hold - 1) send_n = 1'b1;
         if (e == 500) op_a = ~a;
         if (p2 > 0 && e == p2) send_n = 1'b0;
         if (p2 > 0 && e == p2 + 6) send_n = 1'b1;
      end
      chk("msg_completed", {31'd0, fin}, 32'd1);
      chk("busy_cycles", bcnt, 32'd1280);
      chk("done_pulses", dcnt, 32'd1);
      @(posedge clk);
      #1 chk("done_cleared", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit quiet;
      reset_n = 1'b0; send_n = 1'b1; op_a = 4'h0; op_b = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      #1 reset_n = 1'b1;
      repeat (5) @(posedge clk);

      run_msg(4'h9, 4'h8, 64'h39_2B_38_3D_31_31_0D_0A, 5, 0);
      run_msg(4'hF, 4'hF, 64'h46_2B_46_3D_31_45_0D_0A, 5, 400);
      run_msg(4'h0, 4'h0, 64'h30_2B_30_3D_30_30_0D_0A, 3000, 0);
      run_msg(4'h3, 4'hC, 64'h33_2B_43_3D_30_46_0D_0A, 5, 0);

      // Reset during byte3 data bits: only bytes 0..2 complete
      exp_q.push_back(8'h35); exp_q.push_back(8'h2B); exp_q.push_back(8'h33);
      @(posedge clk);
      #2 op_a = 4'h5; op_b = 4'h3; send_n = 1'b0;
      for (int e = 0; e < 3 + 33 * CPB; e++) begin
         @(posedge clk);
         #2;
         if (e == 4) send_n = 1'b1;
      end
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_tx", {31'd0, tx}, 32'd1);
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      #1 reset_n = 1'b1;
      quiet = 1'b1;
      repeat (300) begin
         @(posedge clk);
         #1 if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
      end
      chk("quiet_after_reset", {31'd0, quiet}, 32'd1);

      repeat (20) @(posedge clk);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
